// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide engine: operation codes,
// FSM state encoding and small opcode decode helpers.
package cpu_defs;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV_ST = 2'b10,
        MD_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the E-stage control/hazard logic and
// the multiply/divide engine.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             stall_e_i;
    logic             stall_o;
    logic             ready_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i, stall_e_i,
        input  stall_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i, stall_e_i,
        output stall_o, ready_o, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit_div_iter_core.sv
// Restoring radix-2 divide datapath on unsigned magnitudes: one quotient bit
// per step; exposes the next-step values so the caller can fix up the last one.
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_next_o,
    output logic [WIDTH-1:0] quot_next_o,
    output logic             last_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;

    // One trial subtraction; the dividend shifts out of the quotient register MSB-first
    always_comb begin
        rem_shift_s = {rem_q, quot_q[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, divisor_q};
        if (!diff_s[WIDTH]) begin
            rem_next_o  = diff_s[WIDTH-1:0];
            quot_next_o = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_o  = rem_shift_s[WIDTH-1:0];
            quot_next_o = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    assign last_o = (count_q == CW'(WIDTH-1));

    // Next-state selection: load new operands, advance one step, or hold
    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        if (load_i) begin
            rem_d     = {WIDTH{1'b0}};
            quot_d    = dividend_i;
            divisor_d = divisor_i;
            count_d   = {CW{1'b0}};
        end else if (step_i) begin
            rem_d   = rem_next_o;
            quot_d  = quot_next_o;
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q     <= {WIDTH{1'b0}};
            quot_q    <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            count_q   <= {CW{1'b0}};
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// E-stage MULT/MULTU/DIV/DIVU engine: single-cycle registered multiply,
// 32-step restoring divide with sign fixup, and the E-stage stall request.
module mul_div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    mul_div_unit_if.slave md
);
    localparam int W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic             mul_signed_q, mul_signed_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic             b_zero_q, b_zero_d;

    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] abs_a_s, abs_b_s;
    logic [W2-1:0]    a_ext_s, b_ext_s, product_s;
    logic             div_load_s, div_step_s, div_last_s;
    logic [WIDTH-1:0] rem_next_s, quot_next_s, rem_fix_s, quot_fix_s;

    assign a_neg_s = op_is_signed(md.op_i) & md.a_i[WIDTH-1];
    assign b_neg_s = op_is_signed(md.op_i) & md.b_i[WIDTH-1];
    assign abs_a_s = a_neg_s ? ({WIDTH{1'b0}} - md.a_i) : md.a_i;
    assign abs_b_s = b_neg_s ? ({WIDTH{1'b0}} - md.b_i) : md.b_i;

    // Modular 2W-bit product covers both signed and unsigned forms
    assign a_ext_s   = {{WIDTH{mul_signed_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext_s   = {{WIDTH{mul_signed_q & b_q[WIDTH-1]}}, b_q};
    assign product_s = a_ext_s * b_ext_s;

    assign div_load_s = (state_q == MD_IDLE) & md.start_i & ~md.flush_i & op_is_div(md.op_i);
    assign div_step_s = (state_q == MD_DIV_ST) & ~md.flush_i;

    div_iter_core #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (div_load_s),
        .step_i      (div_step_s),
        .dividend_i  (abs_a_s),
        .divisor_i   (abs_b_s),
        .rem_next_o  (rem_next_s),
        .quot_next_o (quot_next_s),
        .last_o      (div_last_s)
    );

    assign quot_fix_s = q_neg_q ? ({WIDTH{1'b0}} - quot_next_s) : quot_next_s;
    assign rem_fix_s  = r_neg_q ? ({WIDTH{1'b0}} - rem_next_s)  : rem_next_s;

    assign md.stall_o = (((state_q == MD_IDLE) & md.start_i) | (state_q == MD_MUL) |
                         (state_q == MD_DIV_ST)) & ~md.flush_i;
    assign md.ready_o = (state_q == MD_DONE);
    assign md.hi_o    = hi_q;
    assign md.lo_o    = lo_q;

    // Control FSM next state and result capture; flush beats start and completion
    always_comb begin
        state_d      = state_q;
        mul_signed_d = mul_signed_q;
        a_d          = a_q;
        b_d          = b_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        b_zero_d     = b_zero_q;
        case (state_q)
            MD_IDLE: begin
                if (md.start_i && !md.flush_i) begin
                    mul_signed_d = op_is_signed(md.op_i);
                    a_d          = md.a_i;
                    b_d          = md.b_i;
                    q_neg_d      = a_neg_s ^ b_neg_s;
                    r_neg_d      = a_neg_s;
                    b_zero_d     = (md.b_i == {WIDTH{1'b0}});
                    state_d      = op_is_div(md.op_i) ? MD_DIV_ST : MD_MUL;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_MUL: begin
                if (md.flush_i) begin
                    state_d = MD_IDLE;
                end else begin
                    {hi_d, lo_d} = product_s;
                    state_d      = MD_DONE;
                end
            end
            MD_DIV_ST: begin
                if (md.flush_i) begin
                    state_d = MD_IDLE;
                end else if (div_last_s) begin
                    if (b_zero_q) begin
                        hi_d = a_q;
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        hi_d = rem_fix_s;
                        lo_d = quot_fix_s;
                    end
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_DIV_ST;
                end
            end
            MD_DONE: begin
                if (md.flush_i || !md.stall_e_i) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_DONE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= MD_IDLE;
            mul_signed_q <= 1'b0;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            hi_q         <= {WIDTH{1'b0}};
            lo_q         <= {WIDTH{1'b0}};
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            b_zero_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mul_signed_q <= mul_signed_d;
            a_q          <= a_d;
            b_q          <= b_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            b_zero_q     <= b_zero_d;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed plan vectors, randomized
// operations against an arithmetic reference model, hold/flush/reset scenarios.
module tb_mul_div_unit;
    logic clk;
    logic resetn;
    int   compared;
    int   mismatched;

    mul_div_unit_if #(.WIDTH(32)) md ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {ua % ub, ua / ub} >> 0 == 0 ? 64'd0 : {32'((ua % ub)), 32'((ua / ub))};
            end
        endcase
        return r;
    endfunction

    // Issue one op and wait (bounded) for ready; returns stall cycle count and result
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic [31:0] hi, output logic [31:0] lo);
        @(posedge clk);
        #1;
        md.start_i = 1'b1;
        md.op_i    = op;
        md.a_i     = a;
        md.b_i     = b;
        cycles     = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (md.ready_o) break;
            if (md.stall_o) cycles++;
        end
        hi = md.hi_o;
        lo = md.lo_o;
    endtask

    task automatic end_op();
        @(posedge clk);
        #1;
        md.start_i = 1'b0;
    endtask

    task automatic test_reset();
        md.start_i = 1'b0; md.op_i = 2'b00; md.a_i = 32'd0; md.b_i = 32'd0;
        md.flush_i = 1'b0; md.stall_e_i = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        compared++;
        if (md.stall_o !== 1'b0 || md.ready_o !== 1'b0 || md.hi_o !== 32'd0 || md.lo_o !== 32'd0) begin
            mismatched++;
            $display("FAIL reset: stall=%b ready=%b hi=%h lo=%h, expected 0 0 0 0",
                     md.stall_o, md.ready_o, md.hi_o, md.lo_o);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] as  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd100,
                                 32'h1234_5678, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd3, 32'd3, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'd2,
                                 32'h1234_5678, 32'd0};
        logic [31:0] elo [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd14,
                                 32'hFFFF_FFFF, 32'h8000_0000};
        int          elat[6] = '{2, 2, 33, 33, 33, 33};
        int          cyc;
        logic [31:0] hi, lo;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], cyc, hi, lo);
            end_op();
            compared++;
            if (cyc !== elat[i]) begin
                mismatched++;
                $display("FAIL directed_latency[%0d]: got %0d stall cycles, expected %0d", i, cyc, elat[i]);
            end
            compared++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                mismatched++;
                $display("FAIL directed_result[%0d]: got hi=%h lo=%h, expected hi=%h lo=%h",
                         i, hi, lo, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int          cyc;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = ref_md(op, a, b);
            do_op(op, a, b, cyc, hi, lo);
            end_op();
            compared++;
            if (cyc !== (op[1] ? 33 : 2) || hi !== exp[63:32] || lo !== exp[31:0]) begin
                mismatched++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got cyc=%0d hi=%h lo=%h, expected cyc=%0d hi=%h lo=%h",
                         i, op, a, b, cyc, hi, lo, (op[1] ? 33 : 2), exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_done_hold();
        int          cyc;
        logic [31:0] hi, lo;
        do_op(2'b11, 32'd100, 32'd7, cyc, hi, lo);
        md.stall_e_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            compared++;
            if (md.ready_o !== 1'b1 || md.stall_o !== 1'b0 || md.hi_o !== 32'd2 || md.lo_o !== 32'd14) begin
                mismatched++;
                $display("FAIL done_hold[%0d]: ready=%b stall=%b hi=%h lo=%h, expected 1 0 2 14",
                         i, md.ready_o, md.stall_o, md.hi_o, md.lo_o);
            end
        end
        md.stall_e_i = 1'b0;
        end_op();
        @(negedge clk);
        compared++;
        if (md.ready_o !== 1'b0 || md.stall_o !== 1'b0 || md.hi_o !== 32'd2 || md.lo_o !== 32'd14) begin
            mismatched++;
            $display("FAIL done_release: ready=%b stall=%b hi=%h lo=%h, expected 0 0 2 14",
                     md.ready_o, md.stall_o, md.hi_o, md.lo_o);
        end
    endtask

    task automatic test_flush();
        int          cyc;
        logic [31:0] hi, lo, prev_hi, prev_lo;
        prev_hi = md.hi_o;
        prev_lo = md.lo_o;
        @(posedge clk);
        #1;
        md.start_i = 1'b1; md.op_i = 2'b10; md.a_i = 32'hFFFF_FFF9; md.b_i = 32'd2;
        repeat (11) @(posedge clk);
        #1;
        md.flush_i = 1'b1;
        @(negedge clk);
        compared++;
        if (md.stall_o !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_stall: got stall=%b, expected 0", md.stall_o);
        end
        @(posedge clk);
        #1;
        md.flush_i = 1'b0;
        md.start_i = 1'b0;
        @(negedge clk);
        compared++;
        if (md.ready_o !== 1'b0 || md.stall_o !== 1'b0 || md.hi_o !== prev_hi || md.lo_o !== prev_lo) begin
            mismatched++;
            $display("FAIL flush_idle: ready=%b stall=%b hi=%h lo=%h, expected 0 0 %h %h",
                     md.ready_o, md.stall_o, md.hi_o, md.lo_o, prev_hi, prev_lo);
        end
        do_op(2'b01, 32'd3, 32'd5, cyc, hi, lo);
        end_op();
        compared++;
        if (cyc !== 2 || hi !== 32'd0 || lo !== 32'd15) begin
            mismatched++;
            $display("FAIL flush_then_multu: cyc=%0d hi=%h lo=%h, expected 2 0 15", cyc, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int          cyc;
        logic [31:0] hi, lo;
        @(posedge clk);
        #1;
        md.start_i = 1'b1; md.op_i = 2'b11; md.a_i = 32'd1000; md.b_i = 32'd7;
        repeat (6) @(posedge clk);
        #3;
        md.start_i = 1'b0;
        resetn = 1'b0;
        #1;
        compared++;
        if (md.stall_o !== 1'b0 || md.ready_o !== 1'b0 || md.hi_o !== 32'd0 || md.lo_o !== 32'd0) begin
            mismatched++;
            $display("FAIL async_reset: stall=%b ready=%b hi=%h lo=%h, expected 0 0 0 0",
                     md.stall_o, md.ready_o, md.hi_o, md.lo_o);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        do_op(2'b11, 32'd9, 32'd3, cyc, hi, lo);
        end_op();
        compared++;
        if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd3) begin
            mismatched++;
            $display("FAIL reset_then_divu: cyc=%0d hi=%h lo=%h, expected 33 0 3", cyc, hi, lo);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_directed();
        test_random();
        test_done_hold();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
